// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP pipeline: frame geometry, histogram widths,
// histogram FSM encoding and the border-pixel test.
package lbp_pkg;

    localparam int IMG_W    = 128;
    localparam int ADDR_W   = 14;
    localparam int CNT_W    = 15;
    localparam int COORD_W  = ADDR_W / 2;
    localparam int NUM_BINS = 256;
    localparam int BIN_W    = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DUMP  = 2'd1,
        ST_DONE  = 2'd2
    } hist_state_t;

    // Pixel address is {row, col}; a border pixel has no full 3x3 neighbourhood.
    function automatic logic is_border(input logic [ADDR_W-1:0] addr);
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
        row = addr[ADDR_W-1:COORD_W];
        col = addr[COORD_W-1:0];
        return (row == '0) || (row == COORD_W'(IMG_W - 1)) ||
               (col == '0) || (col == COORD_W'(IMG_W - 1));
    endfunction

endpackage

// File: rtl/lbp_hist_bins.sv
// 256-entry bin counter file: saturating increment port, asynchronous read
// port and a clear port used while the histogram is streamed out.
module lbp_hist_bins
    import lbp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    input  logic [BIN_W-1:0] inc_idx,
    input  logic [BIN_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic             clr_en,
    input  logic [BIN_W-1:0] clr_idx
);

    logic [CNT_W-1:0] r_bins [NUM_BINS];

    // NOTE: every bin sits in the reset domain because reset must discard a
    // partial histogram; this keeps the array in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                r_bins[i] <= '0;
            end
        end else begin
            if (inc_en && (r_bins[inc_idx] != CNT_MAX)) begin
                r_bins[inc_idx] <= r_bins[inc_idx] + CNT_W'(1);
            end
            if (clr_en) begin
                r_bins[clr_idx] <= '0;
            end
        end
    end

    assign rd_cnt = r_bins[rd_idx];

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: accumulates one frame, streams 256 bins out on the
// rising edge of finish, and self-clears each bin as it is accepted.
module lbp_hist
    import lbp_pkg::*;
#(
    parameter bit SKIP_BORDER = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [BIN_W-1:0]  lbp_data,
    input  logic              finish,
    output logic              hist_valid,
    input  logic              hist_ready,
    output logic [BIN_W-1:0]  hist_bin,
    output logic [CNT_W-1:0]  hist_count,
    output logic              hist_done,
    output logic              drop_err
);

    hist_state_t      r_state;
    hist_state_t      w_state_next;
    logic             r_finish_q;
    logic             r_hist_valid;
    logic [BIN_W-1:0] r_hist_bin;
    logic             r_hist_done;
    logic             r_drop_err;

    logic             w_finish_rise;
    logic             w_inc_en;
    logic             w_clr_en;
    logic             w_drop;
    logic [CNT_W-1:0] w_rd_cnt;

    assign w_finish_rise = finish & ~r_finish_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_inc_en     = 1'b0;
        w_clr_en     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                w_inc_en = lbp_valid && !(SKIP_BORDER && is_border(lbp_addr));
                if (w_finish_rise) begin
                    w_state_next = ST_DUMP;
                end
            end
            ST_DUMP: begin
                w_drop   = lbp_valid;
                w_clr_en = r_hist_valid && hist_ready;
                if (w_clr_en && (r_hist_bin == BIN_W'(NUM_BINS - 1))) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_drop       = lbp_valid;
                w_state_next = ST_ACCUM;
            end
            default: w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_finish_q   <= 1'b0;
            r_hist_valid <= 1'b0;
            r_hist_bin   <= '0;
            r_hist_done  <= 1'b0;
            r_drop_err   <= 1'b0;
        end else begin
            r_finish_q  <= finish;
            r_hist_done <= 1'b0;
            if ((r_state == ST_ACCUM) && w_finish_rise) begin
                r_hist_valid <= 1'b1;
                r_hist_bin   <= '0;
            end
            // Bin index wraps 255 -> 0, leaving it ready for the next frame.
            if (w_clr_en) begin
                r_hist_bin <= r_hist_bin + BIN_W'(1);
                if (r_hist_bin == BIN_W'(NUM_BINS - 1)) begin
                    r_hist_valid <= 1'b0;
                    r_hist_done  <= 1'b1;
                end
            end
            if (w_drop) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    lbp_hist_bins u_bins (
        .clk     (clk),
        .reset   (reset),
        .inc_en  (w_inc_en),
        .inc_idx (lbp_data),
        .rd_idx  (r_hist_bin),
        .rd_cnt  (w_rd_cnt),
        .clr_en  (w_clr_en),
        .clr_idx (r_hist_bin)
    );

    // The count read is live, so a sample landing on the finish edge is included.
    assign hist_valid = r_hist_valid;
    assign hist_bin   = r_hist_bin;
    assign hist_count = r_hist_valid ? w_rd_cnt : '0;
    assign hist_done  = r_hist_done;
    assign drop_err   = r_drop_err;

endmodule

// File: tb/tb_lbp_hist.sv
// Bench for lbp_hist: two instances (border skip on / off) share stimulus;
// a reference histogram feeds a queue scoreboard popped on each handshake.
module tb_lbp_hist;
    import lbp_pkg::*;

    typedef struct {
        int bin;
        int cnt_a;
        int cnt_b;
    } exp_t;

    typedef struct {
        int         row;
        int         col;
        logic [7:0] code;
        bit         counted_skip;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              finish;
    logic              hist_ready;

    logic              hv_a, hd_a, de_a;
    logic [7:0]        hb_a;
    logic [CNT_W-1:0]  hc_a;
    logic              hv_b, hd_b, de_b;
    logic [7:0]        hb_b;
    logic [CNT_W-1:0]  hc_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_a [NUM_BINS];
    int   model_b [NUM_BINS];
    exp_t sb [$];
    vec_t vecs [9];

    always #5 clk = ~clk;

    // Instance a counts every pixel; instance b skips the border.
    lbp_hist #(.SKIP_BORDER(1'b0)) dut_a (
        .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .hist_valid(hv_a), .hist_ready(hist_ready),
        .hist_bin(hb_a), .hist_count(hc_a), .hist_done(hd_a), .drop_err(de_a)
    );

    lbp_hist #(.SKIP_BORDER(1'b1)) dut_b (
        .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .hist_valid(hv_b), .hist_ready(hist_ready),
        .hist_bin(hb_b), .hist_count(hc_b), .hist_done(hd_b), .drop_err(de_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit border_ref(input int a);
        int r;
        int c;
        r = a / IMG_W;
        c = a % IMG_W;
        return (r == 0) || (r == IMG_W - 1) || (c == 0) || (c == IMG_W - 1);
    endfunction

    function automatic logic [ADDR_W-1:0] pix(input int row, input int col);
        return ADDR_W'(row * IMG_W + col);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NUM_BINS; i++) begin
            model_a[i] = 0;
            model_b[i] = 0;
        end
    endtask

    task automatic bump(input logic [7:0] d, input bit in_b);
        if (model_a[d] < int'(CNT_MAX)) model_a[d]++;
        if (in_b && (model_b[d] < int'(CNT_MAX))) model_b[d]++;
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit in_b);
        lbp_valid = 1'b1;
        lbp_addr  = a;
        lbp_data  = d;
        bump(d, in_b);
        @(posedge clk);
        #1;
        lbp_valid = 1'b0;
    endtask

    task automatic send_frame(input bit addr_codes);
        for (int i = 0; i < IMG_W * IMG_W; i++) begin
            logic [7:0] code;
            code = addr_codes ? i[7:0] : 8'h00;
            send(i[ADDR_W-1:0], code, !border_ref(i));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid_a"}, hv_a, 0);
        check({tag, "_bin_a"},   hb_a, 0);
        check({tag, "_count_a"}, hc_a, 0);
        check({tag, "_done_a"},  hd_a, 0);
        check({tag, "_drop_a"},  de_a, 0);
        check({tag, "_valid_b"}, hv_b, 0);
        check({tag, "_count_b"}, hc_b, 0);
        check({tag, "_drop_b"},  de_b, 0);
    endtask

    // mode 0: ready tied high; mode 1: ready pattern 1,0,0 repeating.
    task automatic readout(input int mode, input int inject_n, input bit coincide, input bit chk_lat);
        int         n;
        int         hs;
        int         done_n;
        bit         prev_stall;
        logic [7:0] pbin;
        logic [CNT_W-1:0] pca;
        logic [CNT_W-1:0] pcb;
        exp_t       e;

        finish = 1'b1;
        if (coincide) begin
            lbp_valid = 1'b1;
            lbp_addr  = pix(10, 10);
            lbp_data  = 8'h22;
            bump(8'h22, 1'b1);
        end
        for (int i = 0; i < NUM_BINS; i++) begin
            sb.push_back('{i, model_a[i], model_b[i]});
        end
        clear_model();
        @(posedge clk);
        #1;
        lbp_valid  = 1'b0;
        hs         = 0;
        done_n     = 0;
        prev_stall = 1'b0;
        pbin       = '0;
        pca        = '0;
        pcb        = '0;
        n          = 1;
        while ((done_n == 0) && (n <= 1500)) begin
            hist_ready = (mode == 0) ? 1'b1 : (((n - 1) % 3) == 0);
            if (inject_n == n) begin
                lbp_valid = 1'b1;
                lbp_addr  = pix(20, 20);
                lbp_data  = 8'h11;
            end
            @(negedge clk);
            if (prev_stall) begin
                check("stall_bin_a", hb_a, pbin);
                check("stall_cnt_a", hc_a, pca);
                check("stall_cnt_b", hc_b, pcb);
            end
            if (hd_a) begin
                done_n = n;
                check("done_valid_low_a", hv_a, 0);
                check("done_b", hd_b, 1);
            end else if (!hv_a) begin
                check("valid_in_dump_a", hv_a, 1);
            end else if (hist_ready) begin
                hs++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("bin_a",   hb_a, e.bin);
                    check("count_a", hc_a, e.cnt_a);
                    check("bin_b",   hb_b, e.bin);
                    check("count_b", hc_b, e.cnt_b);
                end
            end
            prev_stall = hv_a && !hist_ready;
            pbin = hb_a;
            pca  = hc_a;
            pcb  = hc_b;
            @(posedge clk);
            #1;
            lbp_valid = 1'b0;
            n++;
        end
        check("done_seen", (done_n != 0), 1);
        if (chk_lat) check("done_latency", done_n, 257);
        check("handshakes", hs, 256);
        check("sb_empty", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        check("done_one_cycle", hd_a, 0);
        // finish still high: no retrigger of the readout.
        repeat (4) @(negedge clk);
        check("no_retrigger_a", hv_a, 0);
        check("no_retrigger_b", hv_b, 0);
        finish     = 1'b0;
        hist_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{0,   0,   8'h10, 1'b0};
        vecs[1] = '{0,   64,  8'h11, 1'b0};
        vecs[2] = '{127, 5,   8'h12, 1'b0};
        vecs[3] = '{5,   127, 8'h13, 1'b0};
        vecs[4] = '{64,  0,   8'h14, 1'b0};
        vecs[5] = '{1,   1,   8'h15, 1'b1};
        vecs[6] = '{126, 126, 8'h16, 1'b1};
        vecs[7] = '{1,   126, 8'h17, 1'b1};
        vecs[8] = '{126, 1,   8'h18, 1'b1};

        reset      = 1'b0;
        lbp_valid  = 1'b0;
        lbp_addr   = '0;
        lbp_data   = '0;
        finish     = 1'b0;
        hist_ready = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: whole frame of code 0x00; interior is 126*126 = 15876.
        send_frame(1'b0);
        readout(0, 0, 1'b0, 1'b1);
        check("drop_clean_a", de_a, 0);

        // Test 2: codes = addr[7:0], twice; second pass proves the self-clear.
        send_frame(1'b1);
        readout(0, 0, 1'b0, 1'b1);
        send_frame(1'b1);
        readout(0, 0, 1'b0, 1'b1);

        // Test 3 + border table, read out with throttled ready (test 4).
        for (int i = 0; i < 10; i++) begin
            send(pix(5, 10 + i), 8'hA5, 1'b1);
        end
        foreach (vecs[i]) begin
            send(pix(vecs[i].row, vecs[i].col), vecs[i].code, vecs[i].counted_skip);
        end
        readout(1, 0, 1'b0, 1'b0);

        // Test 5: sample coincident with finish counted; sample in DUMP dropped.
        check("drop_pre_b", de_b, 0);
        send(pix(30, 30), 8'h11, 1'b1);
        readout(0, 5, 1'b1, 1'b1);
        check("drop_set_a", de_a, 1);
        check("drop_set_b", de_b, 1);
        send(pix(31, 31), 8'h40, 1'b1);
        readout(0, 0, 1'b0, 1'b1);
        check("drop_sticky_a", de_a, 1);

        // Test 6: reset in the middle of the readout.
        for (int i = 0; i < 20; i++) begin
            send(pix(40, 2 + i), 8'h44, 1'b1);
        end
        begin
            bit found;
            found      = 1'b0;
            finish     = 1'b1;
            hist_ready = 1'b1;
            @(posedge clk);
            #1;
            for (int k = 0; k < 400 && !found; k++) begin
                @(negedge clk);
                if (hv_a && (hb_a == 8'd100)) found = 1'b1;
            end
            check("reached_bin100", found, 1);
            reset = 1'b0;
            #1;
            check_idle_outputs("midreset");
            check("midreset_bin_b", hb_b, 0);
            finish     = 1'b0;
            hist_ready = 1'b0;
            clear_model();
            @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 50; i++) begin
            send(pix(50 + (i / 25), 3 + (i % 25)), 8'h33, 1'b1);
        end
        readout(0, 0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
